os_discard_buffer: RTL and testbench
====================================

// Module: os_discard_buffer
// PURPOSE
//  Overlap-save output stage: receives 2N-sample blocks from the IFFT and discards the first N (circular-aliased) samples.
//  Stores the last N samples and streams them out with a ready/valid handshake.
//  Sits between the IFFT and the equalizer/slicer; mirror of the input overlap buffer feeding the FFT.
// PARAMETERS
//  N   16  block length PART_N (output samples per block; IFFT size 2N); N>=2
//  WI  12  IFFT output sample width, signed
//  WN  9   output width FX_NARROW S(9,7); SH = WI-WN >= 0 LSBs dropped
// PORTS
//  i_clk         in   1   clock
//  i_rst_n       in   1   asynchronous active-low reset
//  i_ifft_start  in   1   1-cycle pulse, at least one cycle before the first valid of a block
//  i_ifft_valid  in   1   qualifies i_ifft_xI/xQ; gaps allowed within a block
//  i_ifft_xI     in   WI  IFFT real sample
//  i_ifft_xQ     in   WI  IFFT imag sample
//  o_in_ready    out  1   high only in S_IDLE: upstream may issue i_ifft_start
//  o_valid       out  1   output sample valid (registered)
//  i_ready       in   1   downstream accepts; transfer = o_valid & i_ready
//  o_yI          out  WN  output real (registered)
//  o_yQ          out  WN  output imag (registered)
//  o_err         out  1   sticky protocol error; cleared only by reset
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=S_IDLE, counters=0, o_valid=0, o_yI=o_yQ=0, o_err=0.
//   o_in_ready=1 after reset. The buffer array is not reset. Mid-operation reset aborts immediately; the partial block is lost.
//  Counters: idx 0..2N-1 (input position); out_idx 0..N-1.
//  FSM:
//   S_IDLE : start -> S_DROP, idx=0. Valid without start -> sets o_err; sample ignored.
//   S_DROP : each valid idx++ and the sample is discarded; valid at idx==N-1 -> S_KEEP.
//   S_KEEP : each valid writes buf[idx-N] = conv(x) and idx++. Valid at idx==2N-1 -> S_DRAIN;
//            the same edge loads o_yI/o_yQ=buf[0], sets o_valid=1, and sets out_idx=0.
//   S_DRAIN: on transfer, out_idx++ and o_y loads buf[out_idx+1]. Transfer at out_idx==N-1 -> o_valid=0, S_IDLE.
//            While o_valid & !i_ready, o_valid/o_yI/o_yQ hold stable.
//  Latency: last kept input edge -> o_valid=1 on the next clock (1 cycle). N outputs take at least N cycles.
//  Start in S_DROP/S_KEEP: o_err=1, block restarts (idx=0, S_DROP).
//  Start or valid in S_DRAIN: o_err=1, ignored; draining continues.
//  Start and valid in the same cycle in S_IDLE: start honoured, valid ignored, o_err=1.
//  One block in flight; the next start is legal only once o_in_ready=1.
//  conv(x) is the WI->WN conversion applied on write, so the buffer is WN wide. SH=0 -> pass-through.
// CONFIGURATION
//  OS_DISCARD_ROUND_EN defined: conv = sat_WN((x + 2^(SH-1)) >>> SH), round half up, saturate to [-2^(WN-1), 2^(WN-1)-1].
//  Undefined: conv = x[WI-1:SH], floor truncation, no saturation.
// STRUCTURE
//  os_pkg: state encoding (S_IDLE..S_DRAIN), clog2 function, SH constant helper.
//  Sub-module os_round_sat (combinational WI->WN conv, macro-controlled), one instance each for I and Q.
//  Top: FSM, idx/out_idx counters, N x WN I/Q register buffers, output register stage.
// TESTING (N=16, WI=12, WN=9, SH=3)
//  1 Block xI=8*i, xQ=-8*i, i=0..31, i_ready=1 -> 16 outputs yI=16..31, yQ=-16..-31, o_valid 1 cycle after the last input, o_err=0.
//  2 Conversion, samples xI=12, 2047, -4 -> truncation gives 1, 255, -1; ROUND_EN gives 2, 255 (saturated), 0.
//  3 Input gaps every other cycle plus i_ready pattern 1010... -> same 16 outputs in order; data stable on stalled cycles.
//  4 Start during S_KEEP at idx=20 -> o_err=1; the following full block of 32 is output correctly.
//  5 Valid in S_IDLE without start, and start during S_DRAIN -> o_err=1, outputs unaffected.
//  6 i_rst_n low during S_DRAIN after 5 transfers -> o_valid=0 and o_in_ready=1 at once; a fresh block then works.

Source files
------------

// File: rtl/os_pkg.sv
// -----------------------------------------------------------------------------
// os_pkg
// Shared definitions for the overlap-save discard buffer: the FSM state
// encoding, a constant-evaluable ceil(log2) helper used to size counters,
// and a helper that derives the number of LSBs dropped in the WI->WN
// sample conversion.
// No ports (package).
// -----------------------------------------------------------------------------
package os_pkg;

  // Block-processing phases: wait for start, skip aliased half, capture
  // the valid half, then stream it out.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DROP  = 2'd1,
    S_KEEP  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Number of LSBs removed when narrowing a WI-bit sample to WN bits.
  function automatic int shiftOf(input int wi, input int wn);
    return wi - wn;
  endfunction

endpackage

// File: rtl/os_round_sat.sv
// -----------------------------------------------------------------------------
// os_round_sat
// Combinational WI -> WN signed sample narrowing applied to IFFT output
// before it is stored.
//   OS_DISCARD_ROUND_EN defined : round half up, then saturate to the WN range
//   OS_DISCARD_ROUND_EN undefined: floor truncation (drop the SH LSBs)
// With WI == WN the sample passes through unchanged in both builds.
// Ports:
//   i_x  in  WI  signed input sample
//   o_y  out WN  signed converted sample
// -----------------------------------------------------------------------------
module os_round_sat
  import os_pkg::*;
#(
  parameter int WI = 12,
  parameter int WN = 9
) (
  input  logic signed [WI-1:0] i_x,
  output logic signed [WN-1:0] o_y
);

  localparam int SH = shiftOf(WI, WN);

`ifdef OS_DISCARD_ROUND_EN
  if (SH == 0) begin : g_pass
    assign o_y = i_x;
  end else begin : g_round
    // Half an output LSB, expressed in input LSBs.
    localparam logic [WI:0] HALF = (WI+1)'(1) << (SH - 1);

    logic [WI:0] w_sum;
    logic [WN:0] w_shifted;
    logic        w_unusedLsb;

    // One guard bit above the sign so adding HALF to the maximum positive
    // value cannot wrap; taking the upper bits is an arithmetic shift.
    assign w_sum       = {i_x[WI-1], i_x} + HALF;
    assign w_shifted   = w_sum[WI:SH];
    assign w_unusedLsb = ^w_sum[SH-1:0];

    // The shifted value is WN+1 bits; if its top two bits disagree it no
    // longer fits in WN bits and is clamped toward its sign.
    always_comb begin
      if (w_shifted[WN] != w_shifted[WN-1]) begin
        o_y = w_shifted[WN] ? {1'b1, {(WN-1){1'b0}}} : {1'b0, {(WN-1){1'b1}}};
      end else begin
        o_y = w_shifted[WN-1:0];
      end
    end
  end
`else
  assign o_y = i_x[WI-1:SH];

  if (SH > 0) begin : g_lsb
    logic w_unusedLsb;
    assign w_unusedLsb = ^i_x[SH-1:0];
  end
`endif

endmodule

// File: rtl/os_discard_buffer.sv
// -----------------------------------------------------------------------------
// os_discard_buffer
// Overlap-save output stage. Each IFFT block carries 2N samples; the first N
// are circularly aliased and thrown away, the last N are narrowed to WN bits,
// stored, and streamed downstream with a ready/valid handshake. Only one
// block is in flight; upstream may start a new one when o_in_ready is high.
// Optional feature macro: OS_DISCARD_ROUND_EN (round+saturate instead of
// floor truncation, see os_round_sat).
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_ifft_start            1-cycle pulse opening a block
//   i_ifft_valid            qualifies i_ifft_xI / i_ifft_xQ (gaps allowed)
//   i_ifft_xI, i_ifft_xQ    WI-bit signed IFFT samples
//   o_in_ready              high while idle: a new block may start
//   o_valid, i_ready        output handshake (transfer = o_valid & i_ready)
//   o_yI, o_yQ              WN-bit signed registered output samples
//   o_err                   sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------
module os_discard_buffer
  import os_pkg::*;
#(
  parameter int N  = 16,
  parameter int WI = 12,
  parameter int WN = 9
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ifft_start,
  input  logic                 i_ifft_valid,
  input  logic signed [WI-1:0] i_ifft_xI,
  input  logic signed [WI-1:0] i_ifft_xQ,
  output logic                 o_in_ready,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic signed [WN-1:0] o_yI,
  output logic signed [WN-1:0] o_yQ,
  output logic                 o_err
);

  localparam int IDXW  = clog2(2 * N);
  localparam int OIDXW = clog2(N);

  localparam logic [IDXW-1:0]  LAST_DROP = IDXW'(N - 1);
  localparam logic [IDXW-1:0]  LAST_KEEP = IDXW'(2 * N - 1);
  localparam logic [IDXW-1:0]  KEEP_BASE = IDXW'(N);
  localparam logic [OIDXW-1:0] LAST_OUT  = OIDXW'(N - 1);

  state_t r_state;
  state_t w_nextState;

  logic [IDXW-1:0]  r_idx;
  logic [OIDXW-1:0] r_outIdx;
  logic             r_valid;
  logic             r_err;
  logic signed [WN-1:0] r_yI;
  logic signed [WN-1:0] r_yQ;

  logic signed [WN-1:0] r_bufI [N];
  logic signed [WN-1:0] r_bufQ [N];

  logic signed [WN-1:0] w_convI;
  logic signed [WN-1:0] w_convQ;

  logic w_xfer;
  logic w_idxClr;
  logic w_idxInc;
  logic w_write;
  logic w_load0;
  logic w_advance;
  logic w_done;
  logic w_errSet;

  logic [IDXW-1:0]  w_wrAddrFull;
  logic [OIDXW-1:0] w_wrAddr;
  logic [OIDXW-1:0] w_rdAddr;
  logic             w_unusedAddr;

  os_round_sat #(.WI(WI), .WN(WN)) u_convI (
    .i_x (i_ifft_xI),
    .o_y (w_convI)
  );

  os_round_sat #(.WI(WI), .WN(WN)) u_convQ (
    .i_x (i_ifft_xQ),
    .o_y (w_convQ)
  );

  assign w_xfer = r_valid & i_ready;

  // In S_KEEP idx runs N..2N-1, so the buffer slot is idx-N; the upper bits
  // of that difference are always zero.
  assign w_wrAddrFull = r_idx - KEEP_BASE;
  assign w_wrAddr     = w_wrAddrFull[OIDXW-1:0];
  assign w_unusedAddr = ^w_wrAddrFull[IDXW-1:OIDXW];

  // Next slot to present; only used while out_idx < N-1.
  assign w_rdAddr = r_outIdx + 1'b1;

  assign o_in_ready = (r_state == S_IDLE);
  assign o_valid    = r_valid;
  assign o_yI       = r_yI;
  assign o_yQ       = r_yQ;
  assign o_err      = r_err;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and datapath strobes. A start seen while collecting a block
  // restarts it (the upstream evidently began a new one); a start or sample
  // seen while draining is only flagged, so buffered data is never corrupted.
  always_comb begin
    w_nextState = r_state;
    w_idxClr    = 1'b0;
    w_idxInc    = 1'b0;
    w_write     = 1'b0;
    w_load0     = 1'b0;
    w_advance   = 1'b0;
    w_done      = 1'b0;
    w_errSet    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (i_ifft_start) begin
          w_nextState = S_DROP;
          w_idxClr    = 1'b1;
        end
        if (i_ifft_valid) begin
          w_errSet = 1'b1;
        end
      end

      S_DROP: begin
        if (i_ifft_start) begin
          w_errSet = 1'b1;
          w_idxClr = 1'b1;
        end else if (i_ifft_valid) begin
          w_idxInc = 1'b1;
          if (r_idx == LAST_DROP) begin
            w_nextState = S_KEEP;
          end
        end
      end

      S_KEEP: begin
        if (i_ifft_start) begin
          w_errSet    = 1'b1;
          w_idxClr    = 1'b1;
          w_nextState = S_DROP;
        end else if (i_ifft_valid) begin
          w_write = 1'b1;
          if (r_idx == LAST_KEEP) begin
            w_nextState = S_DRAIN;
            w_load0     = 1'b1;
            w_idxClr    = 1'b1;
          end else begin
            w_idxInc = 1'b1;
          end
        end
      end

      S_DRAIN: begin
        if (i_ifft_start || i_ifft_valid) begin
          w_errSet = 1'b1;
        end
        if (w_xfer) begin
          if (r_outIdx == LAST_OUT) begin
            w_nextState = S_IDLE;
            w_done      = 1'b1;
          end else begin
            w_advance = 1'b1;
          end
        end
      end

      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Sample storage. Deliberately not reset: contents are always rewritten
  // before being read in a block.
  always_ff @(posedge i_clk) begin
    if (w_write) begin
      r_bufI[w_wrAddr] <= w_convI;
      r_bufQ[w_wrAddr] <= w_convQ;
    end
  end

  // Input position counter and sticky error flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_idxClr) begin
        r_idx <= '0;
      end else if (w_idxInc) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_errSet) begin
        r_err <= 1'b1;
      end
    end
  end

  // Output register stage. Slot 0 was written N-1 edges before the last
  // kept sample, so it can be loaded on the same edge that ends capture.
  // Without a transfer nothing here changes, which keeps data stable
  // under back-pressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_outIdx <= '0;
      r_valid  <= 1'b0;
      r_yI     <= '0;
      r_yQ     <= '0;
    end else begin
      if (w_load0) begin
        r_valid  <= 1'b1;
        r_outIdx <= '0;
        r_yI     <= r_bufI[0];
        r_yQ     <= r_bufQ[0];
      end else if (w_advance) begin
        r_outIdx <= w_rdAddr;
        r_yI     <= r_bufI[w_rdAddr];
        r_yQ     <= r_bufQ[w_rdAddr];
      end else if (w_done) begin
        r_valid  <= 1'b0;
        r_outIdx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_os_discard_buffer.sv
// -----------------------------------------------------------------------------
// tb_os_discard_buffer
// Directed scoreboard bench for os_discard_buffer (N=16, WI=12, WN=9).
// Stimulus pushes expected output samples into queues as the kept half of a
// block is issued; an independent monitor compares every presented output
// against the queue head and pops on each transfer.
// -----------------------------------------------------------------------------
module tb_os_discard_buffer;

  localparam int N  = 16;
  localparam int WI = 12;
  localparam int WN = 9;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic start  = 1'b0;
  logic valid  = 1'b0;
  logic ready  = 1'b1;
  logic signed [WI-1:0] xI = '0;
  logic signed [WI-1:0] xQ = '0;

  logic inReady;
  logic oValid;
  logic err;
  logic signed [WN-1:0] yI;
  logic signed [WN-1:0] yQ;

  int checks   = 0;
  int failures = 0;

  int expI[$];
  int expQ[$];

  int bI[2*N];
  int bQ[2*N];
  int eI[2*N];
  int eQ[2*N];

  os_discard_buffer #(.N(N), .WI(WI), .WN(WN)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ifft_start (start),
    .i_ifft_valid (valid),
    .i_ifft_xI    (xI),
    .i_ifft_xQ    (xQ),
    .o_in_ready   (inReady),
    .o_valid      (oValid),
    .i_ready      (ready),
    .o_yI         (yI),
    .o_yQ         (yQ),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  // Reference narrowing: floor division by 8, or round-half-up then clamp.
  function automatic int convModel(input int x);
    int r;
`ifdef OS_DISCARD_ROUND_EN
    r = (x + 4) >>> 3;
    if (r > 255) r = 255;
    if (r < -256) r = -256;
`else
    r = x >>> 3;
`endif
    return r;
  endfunction

  // Single comparison with failure reporting.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic s, input logic v, input int xi, input int xq);
    start = s;
    valid = v;
    xI    = xi[WI-1:0];
    xQ    = xq[WI-1:0];
    @(posedge clk);
    #1;
    start = 1'b0;
    valid = 1'b0;
  endtask

  // Build a linear block x = mul*i + off and its expected conversions.
  task automatic fillBlock(input int mulI, input int offI, input int mulQ, input int offQ);
    for (int i = 0; i < 2*N; i++) begin
      bI[i] = mulI * i + offI;
      bQ[i] = mulQ * i + offQ;
      eI[i] = convModel(bI[i]);
      eQ[i] = convModel(bQ[i]);
    end
  endtask

  // Issue a start plus 2N samples, optionally with an idle cycle between
  // samples; expected outputs are queued as the kept half goes in.
  task automatic runBlock(input bit gaps);
    applyStimulus(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 2*N; i++) begin
      applyStimulus(1'b0, 1'b1, bI[i], bQ[i]);
      if (i >= N) begin
        expI.push_back(eI[i]);
        expQ.push_back(eQ[i]);
      end
      if (gaps && i != 2*N-1) applyStimulus(1'b0, 1'b0, 0, 0);
    end
  endtask

  // Let the DUT drain the queue; mode 1 toggles ready 1,0,1,0...
  task automatic waitDrain(input int mode);
    bit drained;
    drained = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (expI.size() == 0 && !oValid) begin
        drained = 1'b1;
        break;
      end
      ready = (mode == 1) ? ((c % 2) == 0) : 1'b1;
      @(posedge clk);
      #1;
    end
    ready = 1'b1;
    checks++;
    if (!drained) begin
      failures++;
      $display("[TB] FAIL drain_timeout pending=%0d valid=%0d required pending=0 valid=0", expI.size(), oValid);
      expI.delete();
      expQ.delete();
    end
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented sample must equal the queue head; a transfer
  // consumes it. Checking on the falling edge keeps clear of the active edge.
  always @(negedge clk) begin
    if (rst_n && oValid) begin
      if (expI.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid yI=%0d yQ=%0d required no output", yI, yQ);
      end else begin
        checkOutput("yI", int'(yI), expI[0]);
        checkOutput("yQ", int'(yQ), expQ[0]);
        if (ready) begin
          void'(expI.pop_front());
          void'(expQ.pop_front());
        end
      end
    end
  end

  // Directed sequence.
  initial begin
    // Reset state
    #2;
    checkOutput("rst_valid", oValid, 0);
    checkOutput("rst_in_ready", inReady, 1);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_yI", int'(yI), 0);
    checkOutput("rst_yQ", int'(yQ), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: ramp block, outputs 16..31 / -16..-31, one-cycle latency
    $display("[TB] test 1 ramp block");
    fillBlock(8, 0, -8, 0);
    runBlock(1'b0);
    checkOutput("t1_latency_valid", oValid, 1);
    checkOutput("t1_in_ready_busy", inReady, 0);
    checkOutput("t1_err", err, 0);
    waitDrain(0);
    checkOutput("t1_in_ready_end", inReady, 1);
    checkOutput("t1_valid_end", oValid, 0);

    // 2: conversion corner samples
    $display("[TB] test 2 conversion");
    fillBlock(8, 0, -8, 0);
    bI[16] = 12;   bI[17] = 2047;  bI[18] = -4;
    bQ[16] = 20;   bQ[17] = -2048; bQ[18] = 5;
`ifdef OS_DISCARD_ROUND_EN
    eI[16] = 2;    eI[17] = 255;   eI[18] = 0;
    eQ[16] = 3;    eQ[17] = -256;  eQ[18] = 1;
`else
    eI[16] = 1;    eI[17] = 255;   eI[18] = -1;
    eQ[16] = 2;    eQ[17] = -256;  eQ[18] = 0;
`endif
    runBlock(1'b0);
    waitDrain(0);
    checkOutput("t2_err", err, 0);

    // 3: input gaps and alternating ready
    $display("[TB] test 3 gaps and back-pressure");
    fillBlock(-8, 100, 8, -100);
    runBlock(1'b1);
    waitDrain(1);
    checkOutput("t3_err", err, 0);
    checkOutput("t3_in_ready", inReady, 1);

    // 4: restart while capturing at idx=20
    $display("[TB] test 4 restart during keep");
    applyStimulus(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 77, -77);
    checkOutput("t4_err_before", err, 0);
    checkOutput("t4_valid_before", oValid, 0);
    fillBlock(16, -256, 4, -63);
    runBlock(1'b0);
    checkOutput("t4_err", err, 1);
    waitDrain(0);
    checkOutput("t4_in_ready", inReady, 1);

    // 5: valid while idle, then start/valid during drain
    $display("[TB] test 5 protocol errors");
    resetPulse();
    checkOutput("t5_err_cleared", err, 0);
    applyStimulus(1'b0, 1'b1, 5, 5);
    checkOutput("t5_err_idle_valid", err, 1);
    checkOutput("t5_valid_idle", oValid, 0);
    checkOutput("t5_in_ready_idle", inReady, 1);
    resetPulse();
    fillBlock(8, 0, -8, 0);
    runBlock(1'b0);
    applyStimulus(1'b1, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1000, -1000);
    checkOutput("t5_err_drain", err, 1);
    checkOutput("t5_in_ready_drain", inReady, 0);
    waitDrain(0);
    checkOutput("t5_in_ready_end", inReady, 1);

    // 6: reset in the middle of draining
    $display("[TB] test 6 reset during drain");
    ready = 1'b0;
    fillBlock(4, 0, -4, 0);
    runBlock(1'b0);
    ready = 1'b1;
    repeat (5) applyStimulus(1'b0, 1'b0, 0, 0);
    ready = 1'b0;
    checkOutput("t6_pending", expI.size(), 11);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_valid_reset", oValid, 0);
    checkOutput("t6_in_ready_reset", inReady, 1);
    checkOutput("t6_err_reset", err, 0);
    expI.delete();
    expQ.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    fillBlock(8, 0, -8, 0);
    runBlock(1'b0);
    checkOutput("t6_latency_valid", oValid, 1);
    waitDrain(0);
    checkOutput("t6_err_end", err, 0);
    checkOutput("t6_in_ready_end", inReady, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
